// File: rtl/inst_cache_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// The cache core connects through the slave modport.
interface inst_cache_if;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_hit;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_ren, inst_addr, flush, mem_ack, mem_rdata,
    output inst_data, inst_hit, stall, mem_req, mem_addr
  );

  modport master (
    output inst_ren, inst_addr, flush, mem_ack, mem_rdata,
    input  inst_data, inst_hit, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with a 0-cycle hit path.
// A miss refills the whole line one word at a time from backing memory.
module inst_cache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input logic        clk,
  input logic        rst_n,
  inst_cache_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  // IDLE: lookup | REFILL: read line words from memory | FILL: commit tag and valid
  typedef enum logic [1:0] {IDLE, REFILL, FILL} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   ltag_q, ltag_d;
  logic [IDX_W-1:0]   lidx_q, lidx_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*LINE_WORDS];

  logic [OFF_W-1:0]   a_off;
  logic [IDX_W-1:0]   a_idx;
  logic [TAG_W-1:0]   a_tag;
  logic               hit;
  logic               wr_data, wr_tag;
  logic               unused_addr_bits;

  assign a_off = bus.inst_addr[2 +: OFF_W];
  assign a_idx = bus.inst_addr[2 + OFF_W +: IDX_W];
  assign a_tag = bus.inst_addr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.inst_addr[1:0];

  assign hit           = (state_q == IDLE) & bus.inst_ren & valid_q[a_idx] &
                         (tag_mem[a_idx] == a_tag);
  assign bus.inst_hit  = hit;
  assign bus.inst_data = hit ? data_mem[{a_idx, a_off}] : 32'd0;
  assign bus.stall     = (bus.inst_ren & ~hit) | (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ltag_d       = ltag_q;
    lidx_d       = lidx_q;
    valid_d      = valid_q;
    wr_data      = 1'b0;
    wr_tag       = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = 32'd0;
    case (state_q)
      IDLE: begin
        if (bus.inst_ren && !hit && !bus.flush) begin
          state_d = REFILL;
          ltag_d  = a_tag;
          lidx_d  = a_idx;
          cnt_d   = '0;
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {ltag_q, lidx_q, cnt_q, 2'b00};
        if (bus.mem_ack) begin
          wr_data = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) state_d = FILL;
        end
      end
      FILL: begin
        wr_tag          = 1'b1;
        valid_d[lidx_q] = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides the FILL commit so a line filled under flush stays invalid.
    if (bus.flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ltag_q  <= '0;
      lidx_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ltag_q  <= ltag_d;
      lidx_q  <= lidx_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_data) data_mem[{lidx_q, cnt_q}] <= bus.mem_rdata;
    if (rst_n && wr_tag)  tag_mem[lidx_q]           <= ltag_q;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: refill addresses and hit data are checked
// against scoreboard queues filled when each fetch is issued.
module tb_inst_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_cache_if ifc();

  inst_cache #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  int ack_delay = 0;
  int wait_cnt  = 0;
  int acks_seen = 0;
  bit force_ack = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return ({a[31:4], 4'h0} ^ 32'h0000_00B0) + {30'd0, a[3:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model, evaluated at the falling edge.
  task automatic respond();
    logic [31:0] ea;
    ifc.mem_ack   = 1'b0;
    ifc.mem_rdata = 32'd0;
    if (ifc.mem_req === 1'b1) begin
      ea = (addr_q.size() > 0) ? addr_q[0] : 32'hDEAD_BEEF;
      if (wait_cnt >= ack_delay) begin
        check("mem_addr", ifc.mem_addr, ea);
        if (addr_q.size() > 0) void'(addr_q.pop_front());
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = mem_val(ea);
        wait_cnt = 0;
        acks_seen++;
      end else begin
        check("mem_addr_hold", ifc.mem_addr, ea);
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      if (force_ack) begin
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 32'hBAD0_BAD0;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_mem_req", {31'd0, ifc.mem_req}, 32'd0);
      respond();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input int n_refill,
                       input int exp_stall, input int flush_at,
                       input logic [31:0] swap_addr, input int swap_at);
    int stalls;
    bit done;
    logic [31:0] line;
    stalls = 0;
    done   = 1'b0;
    line   = {addr[31:4], 4'h0};
    for (int r = 0; r < n_refill; r++)
      for (int w = 0; w < 4; w++) addr_q.push_back(line + 32'(w * 4));
    data_q.push_back(mem_val(swap_at >= 0 ? swap_addr : addr));
    ifc.inst_ren  = 1'b1;
    ifc.inst_addr = addr;
    for (int c = 0; c < 200 && !done; c++) begin
      ifc.flush = (c == flush_at);
      if (c == swap_at) ifc.inst_addr = swap_addr;
      @(negedge clk);
      if (ifc.inst_hit === 1'b1) begin
        check({tag, "_data"}, ifc.inst_data, data_q.pop_front());
        check({tag, "_stall_lo"}, {31'd0, ifc.stall}, 32'd0);
        check({tag, "_req_lo"}, {31'd0, ifc.mem_req}, 32'd0);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_refill_words"}, 32'(addr_q.size()), 32'd0);
        done = 1'b1;
      end else begin
        check({tag, "_stall_hi"}, {31'd0, ifc.stall}, 32'd1);
        stalls++;
      end
      respond();
      @(posedge clk);
      #1;
    end
    check({tag, "_no_timeout"}, {31'd0, done}, 32'd1);
    ifc.inst_ren = 1'b0;
    ifc.flush    = 1'b0;
    addr_q.delete();
    data_q.delete();
  endtask

  initial begin
    int base;
    ifc.inst_ren  = 1'b1;
    ifc.inst_addr = 32'h10;
    ifc.flush     = 1'b0;
    ifc.mem_ack   = 1'b0;
    ifc.mem_rdata = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, ifc.mem_req}, 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'd0);
    check("rst_inst_hit", {31'd0, ifc.inst_hit}, 32'd0);
    check("rst_inst_data", ifc.inst_data, 32'd0);
    check("rst_stall_miss", {31'd0, ifc.stall}, 32'd1);
    ifc.inst_ren = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    fetch("cold", 32'h10, 1, 6, -1, 32'h0, -1);
    fetch("hit14", 32'h14, 0, 0, -1, 32'h0, -1);
    fetch("hit1c", 32'h1C, 0, 0, -1, 32'h0, -1);

    fetch("conflict", 32'h110, 1, 6, -1, 32'h0, -1);
    fetch("conflict_back", 32'h10, 1, 6, -1, 32'h0, -1);

    ack_delay = 3;
    fetch("slow", 32'h58, 1, 18, -1, 32'h0, -1);
    ack_delay = 0;
    fetch("slow_hit", 32'h50, 0, 0, -1, 32'h0, -1);

    ifc.flush = 1'b1;
    idle_cycles(1);
    ifc.flush = 1'b0;
    fetch("flush_idle", 32'h10, 1, 6, -1, 32'h0, -1);

    fetch("flush_fill", 32'h64, 2, 12, 5, 32'h0, -1);
    fetch("flush_fill_old", 32'h10, 1, 6, -1, 32'h0, -1);

    fetch("flush_refill", 32'h70, 1, 6, 2, 32'h0, -1);
    fetch("flush_refill_hit", 32'h74, 0, 0, -1, 32'h0, -1);

    fetch("flush_detect", 32'h80, 1, 7, 0, 32'h0, -1);

    fetch("addr_swap", 32'h90, 1, 6, -1, 32'h98, 3);

    idle_cycles(3);

    ifc.inst_ren  = 1'b1;
    ifc.inst_addr = 32'hA0;
    for (int w = 0; w < 4; w++) addr_q.push_back(32'hA0 + 32'(w * 4));
    base = acks_seen;
    for (int c = 0; c < 20 && acks_seen < base + 2; c++) begin
      @(negedge clk);
      respond();
      @(posedge clk);
      #1;
    end
    check("rst_two_acks", 32'(acks_seen - base), 32'd2);
    rst_n = 1'b0;
    ifc.inst_ren = 1'b0;
    @(negedge clk);
    respond();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {31'd0, ifc.mem_req}, 32'd0);
    check("rst_mid_stall", {31'd0, ifc.stall}, 32'd0);
    respond();
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    addr_q.delete();
    idle_cycles(1);
    fetch("after_rst", 32'hA4, 1, 6, -1, 32'h0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
